// File: rtl/psum_accum_sfu_pkg.sv
// Shared sizing, FSM encodings and saturation limits for the psum accumulator.
// No logic and no latency; the constants here set the widths of every block port.
package psum_accum_sfu_pkg;
    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int DEPTH   = 16;
    localparam int RD_LAT  = 2;

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int ROW_W = COL * PSUM_BW;
    localparam int HW    = $clog2(RD_LAT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic signed [PSUM_BW:0] SAT_MAX = (PSUM_BW + 1)'((2 ** (PSUM_BW - 1)) - 1);
    localparam logic signed [PSUM_BW:0] SAT_MIN = (PSUM_BW + 1)'(-(2 ** (PSUM_BW - 1)));

    function automatic int lane_lo(input int lane);
        return lane * PSUM_BW;
    endfunction
endpackage

// File: rtl/psum_accum_sfu_if.sv
// Job control, output-FIFO pop handshake and SRAM write-port bundle.
// Wires only; the consumer pops by asserting ofifo_rd while ofifo_valid is high.
interface psum_accum_sfu_if;
    import psum_accum_sfu_pkg::*;

    logic             start;
    logic [CW-1:0]    num_rows;
    logic [7:0]       num_passes;
    logic             relu_en;
    logic             ofifo_valid;
    logic [ROW_W-1:0] ofifo_out;
    logic             ofifo_rd;
    logic             res_valid;
    logic [ROW_W-1:0] res_out;
    logic [AW-1:0]    res_addr;
    logic             busy;
    logic             done;

    modport master (
        output start, num_rows, num_passes, relu_en, ofifo_valid, ofifo_out,
        input  ofifo_rd, res_valid, res_out, res_addr, busy, done
    );

    modport slave (
        input  start, num_rows, num_passes, relu_en, ofifo_valid, ofifo_out,
        output ofifo_rd, res_valid, res_out, res_addr, busy, done
    );
endinterface

// File: rtl/psum_lane_sat.sv
// One lane: signed add (or bypass on the first pass), clamp to psum range, optional ReLU.
// Purely combinational, zero latency, no backpressure.
module psum_lane_sat
    import psum_accum_sfu_pkg::*;
(
    input  logic signed [PSUM_BW-1:0] in_i,
    input  logic signed [PSUM_BW-1:0] acc_i,
    input  logic                      bypass_i,
    input  logic                      relu_i,
    output logic signed [PSUM_BW-1:0] sum_o
);
    logic signed [PSUM_BW:0] wide;
    logic signed [PSUM_BW-1:0] sat;

    always_comb begin
        wide = bypass_i ? {in_i[PSUM_BW-1], in_i}
                        : {acc_i[PSUM_BW-1], acc_i} + {in_i[PSUM_BW-1], in_i};
        if (wide > SAT_MAX) begin
            sat = SAT_MAX[PSUM_BW-1:0];
        end else if (wide < SAT_MIN) begin
            sat = SAT_MIN[PSUM_BW-1:0];
        end else begin
            sat = wide[PSUM_BW-1:0];
        end
        sum_o = (relu_i && sat[PSUM_BW-1]) ? '0 : sat;
    end
endmodule

// File: rtl/psum_accum_sfu.sv
// Pops psum rows from the MAC output FIFO, accumulates them over several passes and emits finished rows.
// Result one cycle after the last-pass pop; a pop is followed by rd_lat HOLD cycles so stale valid is never sampled.
module psum_accum_sfu
    import psum_accum_sfu_pkg::*;
(
    input logic             clk,
    input logic             reset,
    psum_accum_sfu_if.slave bus
);
    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    row_q, row_d;
    logic [7:0]       pass_q, pass_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [CW-1:0]    nrows_q, nrows_d;
    logic [7:0]       npass_q, npass_d;
    logic             relu_q, relu_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             res_vld_q, res_vld_d;
    logic [ROW_W-1:0] res_dat_q, res_dat_d;
    logic [AW-1:0]    res_addr_q, res_addr_d;

    logic [ROW_W-1:0] acc_mem_q [DEPTH];
    logic [ROW_W-1:0] acc_row, lane_sum;
    logic             pop, last_pass, last_row;

    assign pop       = (state_q == ST_FETCH) && bus.ofifo_valid;
    assign last_pass = (pass_q == npass_q - 8'd1);
    assign last_row  = ({1'b0, row_q} == nrows_q - CW'(1));
    assign acc_row   = acc_mem_q[row_q];

    // ReLU only ever shapes emitted rows; intermediate sums keep their sign.
    for (genvar g = 0; g < COL; g++) begin : g_lane
        psum_lane_sat u_lane (
            .in_i     (bus.ofifo_out[lane_lo(g) +: PSUM_BW]),
            .acc_i    (acc_row[lane_lo(g) +: PSUM_BW]),
            .bypass_i (pass_q == 8'd0),
            .relu_i   (relu_q && last_pass),
            .sum_o    (lane_sum[lane_lo(g) +: PSUM_BW])
        );
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        pass_d     = pass_q;
        hold_d     = hold_q;
        nrows_d    = nrows_q;
        npass_d    = npass_q;
        relu_d     = relu_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        res_vld_d  = 1'b0;
        res_dat_d  = res_dat_q;
        res_addr_d = res_addr_q;
        if (done_q) busy_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !busy_q) begin
                    nrows_d = bus.num_rows;
                    npass_d = bus.num_passes;
                    relu_d  = bus.relu_en;
                    row_d   = '0;
                    pass_d  = '0;
                    busy_d  = 1'b1;
                    state_d = (bus.num_rows == '0 || bus.num_passes == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (pop) begin
                    if (last_pass) begin
                        res_vld_d  = 1'b1;
                        res_dat_d  = lane_sum;
                        res_addr_d = row_q;
                    end
                    if (last_row) begin
                        row_d  = '0;
                        pass_d = pass_q + 8'd1;
                    end else begin
                        row_d = row_q + AW'(1);
                    end
                    if (last_pass && last_row) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_HOLD;
                        hold_d  = HW'(RD_LAT);
                    end
                end
            end
            ST_HOLD: begin
                hold_d = hold_q - HW'(1);
                if (hold_q == HW'(1)) state_d = ST_FETCH;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            pass_q     <= '0;
            hold_q     <= '0;
            nrows_q    <= '0;
            npass_q    <= '0;
            relu_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            res_vld_q  <= 1'b0;
            res_dat_q  <= '0;
            res_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            pass_q     <= pass_d;
            hold_q     <= hold_d;
            nrows_q    <= nrows_d;
            npass_q    <= npass_d;
            relu_q     <= relu_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            res_vld_q  <= res_vld_d;
            res_dat_q  <= res_dat_d;
            res_addr_q <= res_addr_d;
        end
    end

    // Accumulation storage is deliberately not reset; every job overwrites it on pass 0.
    always_ff @(posedge clk) begin
        if (pop && !last_pass) acc_mem_q[row_q] <= lane_sum;
    end

    assign bus.ofifo_rd  = pop;
    assign bus.res_valid = res_vld_q;
    assign bus.res_out   = res_dat_q;
    assign bus.res_addr  = res_addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_psum_accum_sfu.sv
// Randomized and directed bench for psum_accum_sfu with a FIFO model and an arithmetic accumulation reference.
module tb_psum_accum_sfu;
    import psum_accum_sfu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    psum_accum_sfu_if bus();
    psum_accum_sfu dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    logic [ROW_W-1:0] fifo_q [$];
    logic [ROW_W-1:0] stim [$];
    int               pend = 0;
    bit               gate = 1'b0;
    int               cyc = 0;
    int               pop_cyc [$];
    logic [AW-1:0]    got_addr [$];
    logic [ROW_W-1:0] got_dat [$];
    int               last_res_cyc = 0;
    int               done_cnt = 0;
    int               done_cyc = 0;
    int               exp_lane [DEPTH][COL];

    task automatic check_val(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // FIFO model: the popped head stays visible until RD_LAT cycles after the pop.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (pend > 0) begin
                pend--;
                if (pend == 0 && fifo_q.size() > 0) void'(fifo_q.pop_front());
            end
            bus.ofifo_valid = (fifo_q.size() > 0) && !gate;
            bus.ofifo_out   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
            #1;
            if (bus.ofifo_rd) begin
                pend = RD_LAT;
                pop_cyc.push_back(cyc);
            end
            if (bus.res_valid) begin
                got_addr.push_back(bus.res_addr);
                got_dat.push_back(bus.res_out);
                last_res_cyc = cyc;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    function automatic int clamp(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic int rnd_lane();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 65535)) - 32768;
        return int'($urandom_range(0, 400)) - 200;
    endfunction

    function automatic logic [ROW_W-1:0] pack_row(input int l [COL]);
        logic [ROW_W-1:0] v;
        v = '0;
        for (int i = 0; i < COL; i++) v[lane_lo(i) +: PSUM_BW] = PSUM_BW'(l[i]);
        return v;
    endfunction

    // Reference: row r of pass p is stim[p*nrows+r]; clamp after every add, ReLU at the end.
    task automatic model(input int nrows, input int npass, input bit relu);
        for (int r = 0; r < nrows; r++) begin
            for (int i = 0; i < COL; i++) begin
                int acc = 0;
                for (int p = 0; p < npass; p++) begin
                    int v = int'($signed(stim[p * nrows + r][lane_lo(i) +: PSUM_BW]));
                    acc = (p == 0) ? v : clamp(acc + v);
                end
                if (relu && acc < 0) acc = 0;
                exp_lane[r][i] = acc;
            end
        end
    endtask

    task automatic gen_random(input int nrows, input int npass);
        int l [COL];
        stim.delete();
        for (int k = 0; k < nrows * npass; k++) begin
            for (int i = 0; i < COL; i++) l[i] = rnd_lane();
            stim.push_back(pack_row(l));
        end
    endtask

    task automatic start_job(input int nrows, input int npass, input bit relu);
        assert (nrows <= DEPTH) else $error("illegal num_rows %0d", nrows);
        pop_cyc.delete();
        got_addr.delete();
        got_dat.delete();
        done_cnt = 0;
        foreach (stim[k]) fifo_q.push_back(stim[k]);
        bus.num_rows   = CW'(nrows);
        bus.num_passes = 8'(npass);
        bus.relu_en    = relu;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_pops(input int n);
        int k = 0;
        while (pop_cyc.size() < n && k < 500) begin
            tick();
            k++;
        end
        check_val("wait_pops", longint'(pop_cyc.size() >= n), 1);
    endtask

    task automatic wait_done(input string tag, input bit rand_gate);
        int k = 0;
        while (done_cnt == 0 && k < 3000) begin
            if (rand_gate) gate = ($urandom_range(0, 3) == 0);
            tick();
            k++;
        end
        gate = 1'b0;
        check_val({tag, "_done_cnt"}, done_cnt, 1);
        tick();
        check_val({tag, "_busy_after"}, bus.busy, 0);
        check_val({tag, "_done_width"}, bus.done, 0);
    endtask

    task automatic check_job(input string tag, input int nrows, input int npass);
        check_val({tag, "_pops"}, pop_cyc.size(), nrows * npass);
        check_val({tag, "_nres"}, got_dat.size(), nrows);
        for (int r = 0; r < got_dat.size() && r < nrows; r++) begin
            check_val($sformatf("%s_addr%0d", tag, r), got_addr[r], r);
            for (int i = 0; i < COL; i++)
                check_val($sformatf("%s_r%0d_l%0d", tag, r, i),
                          $signed(got_dat[r][lane_lo(i) +: PSUM_BW]), exp_lane[r][i]);
        end
        if (nrows > 0 && npass > 0) check_val({tag, "_done_lag"}, done_cyc - last_res_cyc, 1);
    endtask

    task automatic run_job(input string tag, input int nrows, input int npass, input bit relu,
                           input bit rand_gate);
        model(nrows, npass, relu);
        start_job(nrows, npass, relu);
        wait_done(tag, rand_gate);
        check_job(tag, nrows, npass);
    endtask

    initial begin
        int l [COL];
        int nres;
        int k;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.num_rows   = '0;
        bus.num_passes = '0;
        bus.relu_en    = 1'b0;
        repeat (3) tick();
        check_val("rst_ofifo_rd", bus.ofifo_rd, 0);
        check_val("rst_res_valid", bus.res_valid, 0);
        check_val("rst_res_out", longint'(|bus.res_out), 0);
        check_val("rst_res_addr", bus.res_addr, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);
        reset = 1'b0;
        tick();

        // Single pass, rows of 5 then -3.
        stim.delete();
        foreach (l[i]) l[i] = 5;
        stim.push_back(pack_row(l));
        foreach (l[i]) l[i] = -3;
        stim.push_back(pack_row(l));
        run_job("single", 2, 1, 1'b0, 1'b0);
        check_val("single_busy_during", longint'(got_dat.size()), 2);

        // Three passes of r+i; pops must be exactly RD_LAT+1 apart.
        stim.delete();
        for (int p = 0; p < 3; p++)
            for (int r = 0; r < 4; r++) begin
                foreach (l[i]) l[i] = r + i;
                stim.push_back(pack_row(l));
            end
        run_job("three", 4, 3, 1'b0, 1'b0);
        for (int j = 1; j < pop_cyc.size(); j++)
            check_val($sformatf("three_gap%0d", j), pop_cyc[j] - pop_cyc[j-1], RD_LAT + 1);
        if (got_dat.size() == 4)
            check_val("three_r3_l7", $signed(got_dat[3][lane_lo(7) +: PSUM_BW]), 30);

        // Saturation and ReLU, same data without and with ReLU.
        for (int rl = 0; rl < 2; rl++) begin
            stim.delete();
            foreach (l[i]) l[i] = 0;
            l[0] = 30000; l[1] = -30000; l[2] = -7;
            stim.push_back(pack_row(l));
            l[2] = 2;
            stim.push_back(pack_row(l));
            run_job($sformatf("sat%0d", rl), 1, 2, rl[0], 1'b0);
            if (got_dat.size() > 0) begin
                check_val("sat_pos", $signed(got_dat[0][lane_lo(0) +: PSUM_BW]), 32767);
                check_val("sat_neg", $signed(got_dat[0][lane_lo(1) +: PSUM_BW]), rl == 1 ? 0 : -32768);
                check_val("sat_mix", $signed(got_dat[0][lane_lo(2) +: PSUM_BW]), rl == 1 ? 0 : -5);
            end
        end

        // Backpressure: valid dropped for 10 cycles in the middle of the last pass.
        gen_random(4, 2);
        model(4, 2, 1'b0);
        start_job(4, 2, 1'b0);
        wait_pops(5);
        tick();
        nres = got_dat.size();
        gate = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_val($sformatf("bp_rd%0d", c), bus.ofifo_rd, 0);
        end
        check_val("bp_nres_frozen", got_dat.size(), nres);
        gate = 1'b0;
        wait_done("bp", 1'b0);
        check_job("bp", 4, 2);

        // Reset two cycles after the 3rd pop; leftover FIFO rows must not be popped in IDLE.
        gen_random(4, 2);
        start_job(4, 2, 1'b0);
        wait_pops(3);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_val("mrst_busy", bus.busy, 0);
        check_val("mrst_res_valid", bus.res_valid, 0);
        check_val("mrst_ofifo_rd", bus.ofifo_rd, 0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_val("idle_no_pop", bus.ofifo_rd, 0);
        end
        fifo_q.delete();
        pend = 0;
        tick();
        stim.delete();
        foreach (l[i]) l[i] = 9;
        stim.push_back(pack_row(l));
        run_job("after_rst", 1, 1, 1'b0, 1'b0);

        // Zero-pass and zero-row jobs end without popping.
        for (int z = 0; z < 2; z++) begin
            stim.delete();
            start_job(z == 0 ? 3 : 0, z == 0 ? 0 : 2, 1'b0);
            k = 0;
            while (done_cnt == 0 && k < 6) begin
                tick();
                k++;
            end
            check_val($sformatf("zero%0d_done_lat", z), longint'(done_cnt == 1 && k <= 1), 1);
            check_val($sformatf("zero%0d_pops", z), pop_cyc.size(), 0);
            check_val($sformatf("zero%0d_nres", z), got_dat.size(), 0);
            tick();
            check_val($sformatf("zero%0d_busy", z), bus.busy, 0);
        end

        // A start pulse while busy must not disturb the running job.
        gen_random(3, 2);
        model(3, 2, 1'b1);
        start_job(3, 2, 1'b1);
        wait_pops(2);
        bus.num_rows   = CW'(1);
        bus.num_passes = 8'd1;
        bus.relu_en    = 1'b0;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("busy_start", 1'b0);
        check_job("busy_start", 3, 2);

        // Random configurations with random FIFO stalls.
        for (int j = 0; j < 6; j++) begin
            int nr = int'($urandom_range(1, DEPTH));
            int np = int'($urandom_range(1, 3));
            bit rl = 1'($urandom_range(0, 1));
            gen_random(nr, np);
            run_job($sformatf("rnd%0d", j), nr, np, rl, 1'b1);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
